// File: rtl/scroll_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : scroll_display_driver
// Description : Multiplexed common-anode 7-segment driver that scrolls a window
//               over a writable hex message with per-slot anti-ghost dead time.
// Revision    : 1.0
// ============================================================================
module scroll_display_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int MSG_DEPTH     = 16,
  parameter int DIGIT_CYCLES  = 1024,
  parameter int BLANK_CYCLES  = 64,
  parameter int SCROLL_CYCLES = 5_000_000,
  localparam int ADDR_W       = $clog2(MSG_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [3:0]            wr_data_i,
  input  logic [1:0]            mode_i,
  input  logic [NUM_DIGITS-1:0] dp_in_i,
  output logic [NUM_DIGITS-1:0] anodes_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [ADDR_W-1:0]     base_addr_o,
  output logic                  frame_tick_o
);

  localparam int SLOT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCR_W  = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_BLANK = 2'b11;

  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [DIG_W-1:0]      digit_q, digit_d;
  logic [SCR_W-1:0]      scroll_q, scroll_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [1:0]            mode_q;
  logic [3:0]            mem_q [MSG_DEPTH];

  logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [ADDR_W-1:0]     base_out_q;
  logic                  frame_q, frame_d;

  logic                  slot_wrap;
  logic                  scrolling;
  logic                  lit;
  logic [SCR_W-1:0]      scroll_base;
  logic [ADDR_W-1:0]     rd_addr;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_wrap = (slot_q == SLOT_W'(DIGIT_CYCLES - 1));
    slot_d    = slot_wrap ? '0 : slot_q + 1'b1;
    digit_d   = digit_q;
    if (slot_wrap) begin
      digit_d = (digit_q == '0) ? DIG_W'(NUM_DIGITS - 1) : digit_q - 1'b1;
    end
    frame_d = slot_wrap && (digit_q == '0);
  end

  // Any mode change restarts the scroll period, so the new mode always waits a full period.
  always_comb begin
    scrolling   = (mode_i == MODE_LEFT) || (mode_i == MODE_RIGHT);
    scroll_base = (mode_i != mode_q) ? '0 : scroll_q;
    scroll_d    = '0;
    base_d      = base_q;
    if (scrolling) begin
      if (scroll_base == SCR_W'(SCROLL_CYCLES - 1)) begin
        base_d = (mode_i == MODE_LEFT) ? base_q + 1'b1 : base_q - 1'b1;
      end else begin
        scroll_d = scroll_base + 1'b1;
      end
    end
  end

  always_comb begin
    rd_addr  = base_q + ADDR_W'(NUM_DIGITS - 1) - ADDR_W'(digit_q);
    lit      = (slot_q >= SLOT_W'(BLANK_CYCLES)) && (mode_i != MODE_BLANK);
    anodes_d = '1;
    seg_d    = 7'h7F;
    dp_d     = 1'b1;
    if (lit) begin
      anodes_d = ~(NUM_DIGITS'(1) << digit_q);
      seg_d    = decode(mem_q[rd_addr]);
      dp_d     = ~dp_in_i[digit_q];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q     <= '0;
      digit_q    <= DIG_W'(NUM_DIGITS - 1);
      scroll_q   <= '0;
      base_q     <= '0;
      mode_q     <= MODE_HOLD;
      anodes_q   <= '1;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      base_out_q <= '0;
      frame_q    <= 1'b0;
      for (int i = 0; i < MSG_DEPTH; i++) begin
        mem_q[i] <= 4'(i);
      end
    end else begin
      slot_q     <= slot_d;
      digit_q    <= digit_d;
      scroll_q   <= scroll_d;
      base_q     <= base_d;
      mode_q     <= mode_i;
      anodes_q   <= anodes_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      base_out_q <= base_q;
      frame_q    <= frame_d;
      if (wr_en_i) begin
        mem_q[wr_addr_i] <= wr_data_i;
      end
    end
  end

  assign anodes_o     = anodes_q;
  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign base_addr_o  = base_out_q;
  assign frame_tick_o = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_scroll_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_scroll_display_driver
// Description : Directed self-checking bench for scroll_display_driver.
// Revision    : 1.0
// ============================================================================
module tb_scroll_display_driver;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       wr_en_i;
  logic [3:0] wr_addr_i;
  logic [3:0] wr_data_i;
  logic [1:0] mode_i;
  logic [3:0] dp_in_i;
  logic [3:0] anodes_o;
  logic [6:0] seg_o;
  logic       dp_o;
  logic [3:0] base_addr_o;
  logic       frame_tick_o;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;

  scroll_display_driver #(
    .NUM_DIGITS   (4),
    .MSG_DEPTH    (16),
    .DIGIT_CYCLES (8),
    .BLANK_CYCLES (2),
    .SCROLL_CYCLES(64)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .mode_i      (mode_i),
    .dp_in_i     (dp_in_i),
    .anodes_o    (anodes_o),
    .seg_o       (seg_o),
    .dp_o        (dp_o),
    .base_addr_o (base_addr_o),
    .frame_tick_o(frame_tick_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'hA: return 7'b0001000;
      4'hC: return 7'b0110001;
      4'hE: return 7'b0110000;
      4'hF: return 7'b0111000;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // Advance to just after the e-th clock edge since reset release.
  task automatic goto(input int e);
    while (edge_n < e) begin
      @(posedge clk_i);
      edge_n++;
      #2;
    end
  endtask

  task automatic reset_run(input logic [1:0] m, input logic [3:0] dpin);
    rst_ni  = 1'b0;
    wr_en_i = 1'b0;
    mode_i  = m;
    dp_in_i = dpin;
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    edge_n = 0;
  endtask

  // Checks each digit in the middle of its lit window; p is a frame-aligned edge count.
  task automatic check_window(input int p, input logic [15:0] nibs);
    for (int k = 3; k >= 0; k--) begin
      goto(p + 6 + 8 * (3 - k));
      check_eq($sformatf("an%0d", k), {28'd0, anodes_o}, {28'd0, ~(4'b0001 << k)});
      check_eq($sformatf("seg%0d", k), {25'd0, seg_o}, {25'd0, seg_of(nibs[4*k +: 4])});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_addr_i = '0;
    wr_data_i = '0;

    // 1: reset values, blank lead-in, slot sequencing, frame tick
    reset_run(2'b00, 4'b0000);
    check_eq("rst_an",    anodes_o, 4'hF);
    check_eq("rst_seg",   seg_o, 7'h7F);
    check_eq("rst_dp",    dp_o, 1'b1);
    check_eq("rst_base",  base_addr_o, 4'h0);
    check_eq("rst_frame", frame_tick_o, 1'b0);
    goto(1);  check_eq("t1_blank_an", anodes_o, 4'hF);
    goto(2);  check_eq("t1_blank_an2", anodes_o, 4'hF);
    goto(3);  check_eq("t1_an3", anodes_o, 4'b0111);
              check_eq("t1_seg0", seg_o, 7'b0000001);
              check_eq("t1_dp", dp_o, 1'b1);
    goto(8);  check_eq("t1_an3_last", anodes_o, 4'b0111);
    goto(9);  check_eq("t1_dead", anodes_o, 4'hF);
    goto(11); check_eq("t1_an2", anodes_o, 4'b1011);
              check_eq("t1_seg1", seg_o, 7'b1001111);
    goto(31); check_eq("t1_frame_lo", frame_tick_o, 1'b0);
    goto(32); check_eq("t1_frame_hi", frame_tick_o, 1'b1);
    goto(33); check_eq("t1_frame_lo2", frame_tick_o, 1'b0);
    goto(64); check_eq("t1_frame_hi2", frame_tick_o, 1'b1);

    // 2: scroll left, including wrap of the window past the end of memory
    reset_run(2'b01, 4'b0000);
    goto(64); check_eq("t2_base_pre", base_addr_o, 4'h0);
    goto(66); check_eq("t2_base1", base_addr_o, 4'h1);
    check_window(64, 16'h1234);
    check_window(960, 16'hF012);
    check_eq("t2_base15", base_addr_o, 4'hF);

    // 3: scroll right, hold mid-period, re-entry needs a full period
    reset_run(2'b10, 4'b0000);
    check_window(64, 16'hF012);
    goto(104); mode_i = 2'b00;
    goto(130); check_eq("t3_hold", base_addr_o, 4'hF);
    mode_i = 2'b10;
    goto(193); check_eq("t3_reentry_wait", base_addr_o, 4'hF);
    goto(196); check_eq("t3_reentry_step", base_addr_o, 4'hE);

    // 4: write to displayed address, decimal point on an1
    reset_run(2'b00, 4'b0010);
    goto(12); check_eq("t4_dp_an2", dp_o, 1'b1);
    goto(18); check_eq("t4_dead_an", anodes_o, 4'hF);
              check_eq("t4_dead_dp", dp_o, 1'b1);
    goto(20); check_eq("t4_an1", anodes_o, 4'b1101);
              check_eq("t4_seg_old", seg_o, 7'b0010010);
              check_eq("t4_dp_lit", dp_o, 1'b0);
    wr_en_i = 1'b1; wr_addr_i = 4'd2; wr_data_i = 4'hA;
    goto(21); wr_en_i = 1'b0;
              check_eq("t4_seg_wredge", seg_o, 7'b0010010);
    goto(22); check_eq("t4_seg_new", seg_o, 7'b0001000);
    goto(26); check_eq("t4_dp_off", dp_o, 1'b1);

    // 5: blank mode for longer than a scroll period, then resume
    dp_in_i = 4'b0000;
    mode_i  = 2'b11;
    for (int e = 27; e <= 96; e++) begin
      goto(e);
      check_eq("t5_blank", {anodes_o, seg_o, dp_o}, 12'hFFF);
    end
    check_eq("t5_base", base_addr_o, 4'h0);
    mode_i = 2'b00;
    goto(100); check_eq("t5_resume_an", anodes_o, 4'b0111);
               check_eq("t5_resume_seg", seg_o, 7'b0000001);

    // 6: scroll to 5, write, then asynchronous reset mid-slot
    reset_run(2'b01, 4'b0000);
    goto(322); wr_en_i = 1'b1; wr_addr_i = 4'd7; wr_data_i = 4'hC;
    goto(323); wr_addr_i = 4'd2; wr_data_i = 4'hE;
    goto(324); wr_en_i = 1'b0;
    check_window(320, 16'h56C8);
    check_eq("t6_base5", base_addr_o, 4'h5);
    goto(352);
    rst_ni = 1'b0;
    #1;
    check_eq("t6_async", {anodes_o, seg_o, dp_o, base_addr_o, frame_tick_o}, {4'hF, 7'h7F, 1'b1, 4'h0, 1'b0});
    mode_i = 2'b00;
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    edge_n = 0;
    check_window(0, 16'h0123);
    goto(31); check_eq("t6_base0", base_addr_o, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
